// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - icache/dcache arbiter onto the proc2mem bus with tag-indexed return routing
//
// Purpose: grants one of two memory requesters (icache, dcache) onto the
// single proc2mem bus each cycle, records the owner of every accepted load
// under the memory tag it was given, and steers each returning
// mem2proc_data/tag back to the requester that issued the load.
//
// Ports:
//   clock, reset            - system clock, asynchronous active-high reset
//   ic_cmd/ic_addr          - icache request (cmd 0 NONE, 1 LOAD, 2 STORE)
//   dc_cmd/dc_addr/dc_data  - dcache request and store data
//   mem2proc_response       - tag accepted this cycle (0 = rejected)
//   mem2proc_data/tag       - returning load data and its tag (tag 0 = none)
//   proc2mem_command/addr/data - bus drive for the granted requester
//   ic_response/dc_response - mem2proc_response forwarded to the grantee only
//   ic_ret_*/dc_ret_*       - routed load return (valid, tag, data)
//   outstanding_cnt         - loads currently in flight
//   stray_tag               - pulse: nonzero return tag with no table entry

module mem_bus_arbiter #(
  parameter int XLEN            = 32,
  parameter int NUM_TAGS        = 15,
  parameter int MAX_OUTSTANDING = 8,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [1:0]      ic_cmd,
  input  logic [XLEN-1:0] ic_addr,
  input  logic [1:0]      dc_cmd,
  input  logic [XLEN-1:0] dc_addr,
  input  logic [63:0]     dc_data,
  input  logic [3:0]      mem2proc_response,
  input  logic [63:0]     mem2proc_data,
  input  logic [3:0]      mem2proc_tag,
  output logic [1:0]      proc2mem_command,
  output logic [XLEN-1:0] proc2mem_addr,
  output logic [63:0]     proc2mem_data,
  output logic [3:0]      ic_response,
  output logic [3:0]      dc_response,
  output logic            ic_ret_valid,
  output logic [3:0]      ic_ret_tag,
  output logic [63:0]     ic_ret_data,
  output logic            dc_ret_valid,
  output logic [3:0]      dc_ret_tag,
  output logic [63:0]     dc_ret_data,
  output logic [3:0]      outstanding_cnt,
  output logic            stray_tag
);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  localparam int          SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]  MAX_CNT    = 4'(MAX_OUTSTANDING);

  // Ownership table, indexed directly by the 4-bit memory tag. Entry 0 is
  // never allocated because a zero response means "rejected".
  logic [15:0]   valid_q, valid_d;
  logic [15:0]   owner_dc_q, owner_dc_d;   // 1 = dcache owns the tag
  logic [3:0]    outstanding_q, outstanding_d;
  logic [SW-1:0] starve_q, starve_d;

  logic ic_req, dc_req, ic_elig, dc_elig, full, prefer_ic;
  logic gnt_ic, gnt_dc;
  logic accepted, ic_acc, dc_acc, alloc;
  logic resp_in_range, tag_in_range, ret_hit, ret_to_dc;

  // ---------------- arbitration ----------------
  always_comb begin
    ic_req    = (ic_cmd == CMD_LOAD) || (ic_cmd == CMD_STORE);
    dc_req    = (dc_cmd == CMD_LOAD) || (dc_cmd == CMD_STORE);
    full      = (outstanding_q == MAX_CNT);
    // A full table blocks loads only; stores never allocate a tag.
    ic_elig   = ic_req && !(full && (ic_cmd == CMD_LOAD));
    dc_elig   = dc_req && !(full && (dc_cmd == CMD_LOAD));
    prefer_ic = (starve_q == STARVE_MAX) && ic_req;

    gnt_ic = 1'b0;
    gnt_dc = 1'b0;
    if (prefer_ic) begin
      if (ic_elig)      gnt_ic = 1'b1;
      else if (dc_elig) gnt_dc = 1'b1;
    end else begin
      if (dc_elig)      gnt_dc = 1'b1;
      else if (ic_elig) gnt_ic = 1'b1;
    end
  end

  // ---------------- accept / return decode ----------------
  always_comb begin
    accepted      = (mem2proc_response != 4'd0);
    ic_acc        = gnt_ic && accepted;
    dc_acc        = gnt_dc && accepted;
    resp_in_range = accepted && (32'(mem2proc_response) <= 32'(NUM_TAGS));
    alloc         = resp_in_range &&
                    ((ic_acc && (ic_cmd == CMD_LOAD)) || (dc_acc && (dc_cmd == CMD_LOAD)));
    tag_in_range  = (mem2proc_tag != 4'd0) && (32'(mem2proc_tag) <= 32'(NUM_TAGS));
    ret_hit       = tag_in_range && valid_q[mem2proc_tag];
    ret_to_dc     = owner_dc_q[mem2proc_tag];
  end

  // ---------------- next state ----------------
  always_comb begin
    valid_d       = valid_q;
    owner_dc_d    = owner_dc_q;
    outstanding_d = outstanding_q;
    starve_d      = starve_q;

    // Clear on return first so that a same-tag allocation in the same cycle
    // takes precedence and leaves the entry valid under its new owner.
    if (ret_hit) valid_d[mem2proc_tag] = 1'b0;
    if (alloc) begin
      valid_d[mem2proc_response]    = 1'b1;
      owner_dc_d[mem2proc_response] = gnt_dc;
    end

    case ({alloc, ret_hit})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    if (!ic_req || ic_acc)
      starve_d = '0;
    else if (dc_acc && (starve_q != STARVE_MAX))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q       <= '0;
      owner_dc_q    <= '0;
      outstanding_q <= '0;
      starve_q      <= '0;
    end else begin
      valid_q       <= valid_d;
      owner_dc_q    <= owner_dc_d;
      outstanding_q <= outstanding_d;
      starve_q      <= starve_d;
    end
  end

  // ---------------- outputs ----------------
  // Combinational outputs are forced quiet while reset is held so the bus is
  // idle immediately on an asynchronous assertion.
  always_comb begin
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    ic_response      = 4'd0;
    dc_response      = 4'd0;
    ic_ret_valid     = 1'b0;
    ic_ret_tag       = 4'd0;
    ic_ret_data      = '0;
    dc_ret_valid     = 1'b0;
    dc_ret_tag       = 4'd0;
    dc_ret_data      = '0;
    stray_tag        = 1'b0;

    if (!reset) begin
      if (gnt_dc) begin
        proc2mem_command = dc_cmd;
        proc2mem_addr    = dc_addr;
        proc2mem_data    = dc_data;
        dc_response      = mem2proc_response;
      end else if (gnt_ic) begin
        proc2mem_command = ic_cmd;
        proc2mem_addr    = ic_addr;
        ic_response      = mem2proc_response;
      end

      if (ret_hit) begin
        if (ret_to_dc) begin
          dc_ret_valid = 1'b1;
          dc_ret_tag   = mem2proc_tag;
          dc_ret_data  = mem2proc_data;
        end else begin
          ic_ret_valid = 1'b1;
          ic_ret_tag   = mem2proc_tag;
          ic_ret_data  = mem2proc_data;
        end
      end

      stray_tag = (mem2proc_tag != 4'd0) && !ret_hit;
    end
  end

  assign outstanding_cnt = outstanding_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - table-driven and sequence checks for mem_bus_arbiter

module tb_mem_bus_arbiter;

  localparam logic [1:0] NO = 2'd0;
  localparam logic [1:0] LD = 2'd1;
  localparam logic [1:0] ST = 2'd2;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  ic_cmd, dc_cmd;
  logic [31:0] ic_addr, dc_addr;
  logic [63:0] dc_data, mem2proc_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  ic_response, dc_response;
  logic        ic_ret_valid, dc_ret_valid;
  logic [3:0]  ic_ret_tag, dc_ret_tag;
  logic [63:0] ic_ret_data, dc_ret_data;
  logic [3:0]  outstanding_cnt;
  logic        stray_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_cmd(ic_cmd), .ic_addr(ic_addr),
    .dc_cmd(dc_cmd), .dc_addr(dc_addr), .dc_data(dc_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .ic_response(ic_response), .dc_response(dc_response),
    .ic_ret_valid(ic_ret_valid), .ic_ret_tag(ic_ret_tag), .ic_ret_data(ic_ret_data),
    .dc_ret_valid(dc_ret_valid), .dc_ret_tag(dc_ret_tag), .dc_ret_data(dc_ret_data),
    .outstanding_cnt(outstanding_cnt), .stray_tag(stray_tag)
  );

  typedef struct {
    logic [1:0]  icc;   logic [31:0] ica;
    logic [1:0]  dcc;   logic [31:0] dca;   logic [63:0] dcd;
    logic [3:0]  resp;  logic [3:0]  rtag;  logic [63:0] rdata;
    logic [1:0]  ecmd;  logic [31:0] eaddr; logic [63:0] edata;
    logic [3:0]  eicr;  logic [3:0]  edcr;
    logic        eicv;  logic        edcv;
    logic [3:0]  ertag; logic [63:0] erdata;
    logic        estray; logic [3:0] ecnt;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] icc, input logic [31:0] ica,
                        input logic [1:0] dcc, input logic [31:0] dca, input logic [63:0] dcd,
                        input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
    ic_cmd = icc; ic_addr = ica;
    dc_cmd = dcc; dc_addr = dca; dc_data = dcd;
    mem2proc_response = resp; mem2proc_tag = rtag; mem2proc_data = rdata;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // icc ica      dcc dca      dcd     resp  rtag  rdata  | ecmd eaddr    edata   eicr  edcr  icv dcv ertag rdata  stray cnt
    vecs[0]  = '{LD, 32'h100, LD, 32'h200, 64'h1111, 4'd3, 4'd0, 64'h0,     LD, 32'h200, 64'h1111, 4'd0, 4'd3, 1'b0, 1'b0, 4'd0, 64'h0,     1'b0, 4'd0};
    vecs[1]  = '{LD, 32'h100, NO, 32'h0,   64'h0,    4'd4, 4'd0, 64'h0,     LD, 32'h100, 64'h0,    4'd4, 4'd0, 1'b0, 1'b0, 4'd0, 64'h0,     1'b0, 4'd1};
    vecs[2]  = '{NO, 32'h0,   NO, 32'h0,   64'h0,    4'd0, 4'd4, 64'hDEAD,  NO, 32'h0,   64'h0,    4'd0, 4'd0, 1'b1, 1'b0, 4'd4, 64'hDEAD,  1'b0, 4'd2};
    vecs[3]  = '{NO, 32'h0,   NO, 32'h0,   64'h0,    4'd0, 4'd3, 64'hBEEF,  NO, 32'h0,   64'h0,    4'd0, 4'd0, 1'b0, 1'b1, 4'd3, 64'hBEEF,  1'b0, 4'd1};
    vecs[4]  = '{NO, 32'h0,   NO, 32'h0,   64'h0,    4'd0, 4'd7, 64'h1,     NO, 32'h0,   64'h0,    4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 64'h0,     1'b1, 4'd0};
    vecs[5]  = '{NO, 32'h0,   ST, 32'h300, 64'hCAFE, 4'd2, 4'd0, 64'h0,     ST, 32'h300, 64'hCAFE, 4'd0, 4'd2, 1'b0, 1'b0, 4'd0, 64'h0,     1'b0, 4'd0};
    vecs[6]  = '{NO, 32'h0,   NO, 32'h0,   64'h0,    4'd0, 4'd2, 64'h2,     NO, 32'h0,   64'h0,    4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 64'h0,     1'b1, 4'd0};
    vecs[7]  = '{LD, 32'h700, LD, 32'h800, 64'h0,    4'd0, 4'd0, 64'h0,     LD, 32'h800, 64'h0,    4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 64'h0,     1'b0, 4'd0};
    vecs[8]  = '{NO, 32'h0,   LD, 32'h400, 64'h0,    4'd5, 4'd0, 64'h0,     LD, 32'h400, 64'h0,    4'd0, 4'd5, 1'b0, 1'b0, 4'd0, 64'h0,     1'b0, 4'd0};
    vecs[9]  = '{LD, 32'h500, NO, 32'h0,   64'h0,    4'd5, 4'd5, 64'h55,    LD, 32'h500, 64'h0,    4'd5, 4'd0, 1'b0, 1'b1, 4'd5, 64'h55,    1'b0, 4'd1};
    vecs[10] = '{NO, 32'h0,   NO, 32'h0,   64'h0,    4'd0, 4'd5, 64'h66,    NO, 32'h0,   64'h0,    4'd0, 4'd0, 1'b1, 1'b0, 4'd5, 64'h66,    1'b0, 4'd1};
    vecs[11] = '{NO, 32'h0,   NO, 32'h0,   64'h0,    4'd0, 4'd5, 64'h67,    NO, 32'h0,   64'h0,    4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 64'h0,     1'b1, 4'd0};
    vecs[12] = '{NO, 32'h0,   LD, 32'h600, 64'h0,    4'd6, 4'd0, 64'h0,     LD, 32'h600, 64'h0,    4'd0, 4'd6, 1'b0, 1'b0, 4'd0, 64'h0,     1'b0, 4'd0};
    vecs[13] = '{LD, 32'h610, NO, 32'h0,   64'h0,    4'd7, 4'd6, 64'h77,    LD, 32'h610, 64'h0,    4'd7, 4'd0, 1'b0, 1'b1, 4'd6, 64'h77,    1'b0, 4'd1};
    vecs[14] = '{NO, 32'h0,   NO, 32'h0,   64'h0,    4'd0, 4'd7, 64'h88,    NO, 32'h0,   64'h0,    4'd0, 4'd0, 1'b1, 1'b0, 4'd7, 64'h88,    1'b0, 4'd1};
    vecs[15] = '{NO, 32'h0,   NO, 32'h0,   64'h0,    4'd0, 4'd0, 64'h0,     NO, 32'h0,   64'h0,    4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 64'h0,     1'b0, 4'd0};

    // Reset held with active-looking inputs: every output must stay quiet.
    reset = 1'b1;
    set_in(LD, 32'h100, LD, 32'h200, 64'hFF, 4'd3, 4'd3, 64'h99);
    #3;
    chk("rst_cmd",    64'(proc2mem_command), 64'd0);
    chk("rst_addr",   64'(proc2mem_addr),    64'd0);
    chk("rst_data",   proc2mem_data,         64'd0);
    chk("rst_dcresp", 64'(dc_response),      64'd0);
    chk("rst_rv",     64'({ic_ret_valid, dc_ret_valid}), 64'd0);
    chk("rst_stray",  64'(stray_tag),        64'd0);
    chk("rst_cnt",    64'(outstanding_cnt),  64'd0);
    next_cycle();
    reset = 1'b0;
    set_in(NO, 32'h0, NO, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);

    // Idle for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      #5;
      chk($sformatf("idle%0d_cmd", c), 64'(proc2mem_command), 64'd0);
      chk($sformatf("idle%0d_rv", c),  64'({ic_ret_valid, dc_ret_valid}), 64'd0);
      chk($sformatf("idle%0d_cnt", c), 64'(outstanding_cnt), 64'd0);
      next_cycle();
    end

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      set_in(vecs[i].icc, vecs[i].ica, vecs[i].dcc, vecs[i].dca, vecs[i].dcd,
             vecs[i].resp, vecs[i].rtag, vecs[i].rdata);
      #5;
      chk($sformatf("v%0d_cmd", i),   64'(proc2mem_command), 64'(vecs[i].ecmd));
      chk($sformatf("v%0d_addr", i),  64'(proc2mem_addr),    64'(vecs[i].eaddr));
      chk($sformatf("v%0d_data", i),  proc2mem_data,         vecs[i].edata);
      chk($sformatf("v%0d_icr", i),   64'(ic_response),      64'(vecs[i].eicr));
      chk($sformatf("v%0d_dcr", i),   64'(dc_response),      64'(vecs[i].edcr));
      chk($sformatf("v%0d_icv", i),   64'(ic_ret_valid),     64'(vecs[i].eicv));
      chk($sformatf("v%0d_dcv", i),   64'(dc_ret_valid),     64'(vecs[i].edcv));
      if (vecs[i].eicv) begin
        chk($sformatf("v%0d_ictag", i),  64'(ic_ret_tag), 64'(vecs[i].ertag));
        chk($sformatf("v%0d_icdata", i), ic_ret_data,     vecs[i].erdata);
      end
      if (vecs[i].edcv) begin
        chk($sformatf("v%0d_dctag", i),  64'(dc_ret_tag), 64'(vecs[i].ertag));
        chk($sformatf("v%0d_dcdata", i), dc_ret_data,     vecs[i].erdata);
      end
      chk($sformatf("v%0d_stray", i), 64'(stray_tag),       64'(vecs[i].estray));
      chk($sformatf("v%0d_cnt", i),   64'(outstanding_cnt), 64'(vecs[i].ecnt));
      next_cycle();
    end

    // Starvation: dcache wins 4 times, icache forced through on the 5th.
    for (int i = 0; i < 5; i++) begin
      set_in(LD, 32'h1000, LD, 32'h2000 + 32'(i), 64'h0, 4'(i + 1), 4'd0, 64'h0);
      #5;
      if (i < 4) begin
        chk($sformatf("starve%0d_addr", i), 64'(proc2mem_addr), 64'(32'h2000 + 32'(i)));
        chk($sformatf("starve%0d_dcr", i),  64'(dc_response),   64'(i + 1));
        chk($sformatf("starve%0d_icr", i),  64'(ic_response),   64'd0);
      end else begin
        chk("starve4_addr", 64'(proc2mem_addr), 64'h1000);
        chk("starve4_icr",  64'(ic_response),   64'd5);
        chk("starve4_dcr",  64'(dc_response),   64'd0);
      end
      next_cycle();
    end
    // Counter cleared: dcache priority is back.
    set_in(LD, 32'h1000, LD, 32'h2005, 64'h0, 4'd6, 4'd0, 64'h0);
    #5;
    chk("starve_clr_addr", 64'(proc2mem_addr), 64'h2005);
    chk("starve_clr_dcr",  64'(dc_response),   64'd6);
    next_cycle();

    // Fill to MAX_OUTSTANDING.
    for (int i = 6; i < 8; i++) begin
      set_in(NO, 32'h0, LD, 32'h2000 + 32'(i), 64'h0, 4'(i + 1), 4'd0, 64'h0);
      next_cycle();
    end
    set_in(NO, 32'h0, LD, 32'h2100, 64'h5, 4'd9, 4'd0, 64'h0);
    #5;
    chk("full_cnt",    64'(outstanding_cnt),  64'd8);
    chk("full_ld_cmd", 64'(proc2mem_command), 64'd0);
    chk("full_ld_dcr", 64'(dc_response),      64'd0);
    next_cycle();
    set_in(NO, 32'h0, ST, 32'h3000, 64'hABCD, 4'd9, 4'd0, 64'h0);
    #5;
    chk("full_st_cmd",  64'(proc2mem_command), 64'(ST));
    chk("full_st_data", proc2mem_data,         64'hABCD);
    chk("full_st_dcr",  64'(dc_response),      64'd9);
    next_cycle();

    // Reset mid-flight: active outputs, then asynchronous reset mid-cycle.
    set_in(NO, 32'h0, ST, 32'h3008, 64'h77, 4'd10, 4'd1, 64'h1234);
    #5;
    chk("pre_rst_cnt",  64'(outstanding_cnt),  64'd8);
    chk("pre_rst_cmd",  64'(proc2mem_command), 64'(ST));
    chk("pre_rst_dcv",  64'(dc_ret_valid),     64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_cmd",  64'(proc2mem_command), 64'd0);
    chk("mid_rst_addr", 64'(proc2mem_addr),    64'd0);
    chk("mid_rst_data", proc2mem_data,         64'd0);
    chk("mid_rst_dcr",  64'(dc_response),      64'd0);
    chk("mid_rst_dcv",  64'(dc_ret_valid),     64'd0);
    chk("mid_rst_cnt",  64'(outstanding_cnt),  64'd0);
    next_cycle();
    reset = 1'b0;
    set_in(NO, 32'h0, NO, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    next_cycle();
    set_in(NO, 32'h0, NO, 32'h0, 64'h0, 4'd0, 4'd2, 64'h2222);
    #5;
    chk("post_rst_stray", 64'(stray_tag),        64'd1);
    chk("post_rst_rv",    64'({ic_ret_valid, dc_ret_valid}), 64'd0);
    chk("post_rst_cnt",   64'(outstanding_cnt),  64'd0);
    next_cycle();
    set_in(NO, 32'h0, NO, 32'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    #5;
    chk("post_rst_cnt2",  64'(outstanding_cnt),  64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
